// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: op codes, sequencer states and beat-count helpers for the stack sequencer
package stack_seq_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_RTI  = 3'd5,
        OP_INT  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEAT1,
        S_BEAT2,
        S_BEAT3,
        S_DONE
    } state_e;

    function automatic int sp_reset_of(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic op_e decode_op(input logic [2:0] code);
        return (code >= 3'd1 && code <= 3'd5) ? op_e'(code) : OP_NONE;
    endfunction

    function automatic logic [1:0] beats_of(input op_e op);
        return (op == OP_RTI || op == OP_INT) ? 2'd3 :
               (op == OP_CALL || op == OP_RET) ? 2'd2 :
               (op == OP_NONE) ? 2'd0 : 2'd1;
    endfunction

endpackage

// File: rtl/stack_pointer.sv
// stack_pointer: downward-growing SP register with beat address and sticky over/underflow flag
module stack_pointer #(
    parameter int ADDR_W   = 12,
    parameter int SP_RESET = (1 << ADDR_W) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] sp_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              fault_o
);
    localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(SP_RESET);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    logic [ADDR_W-1:0] sp_q, sp_d, sp_inc;
    logic              fault_q, fault_d;

    // Next SP and fault: push writes at SP then decrements, pop increments then reads
    always_comb begin
        sp_inc  = sp_q + ONE;
        sp_d    = push_i ? sp_q - ONE : pop_i ? sp_inc : sp_q;
        fault_d = fault_q | (push_i && sp_q == '0) | (pop_i && sp_q == SP_RST);
        addr_o  = pop_i ? sp_inc : sp_q;
    end

    // SP and fault registers; fault only clears on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q    <= SP_RST;
            fault_q <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            fault_q <= fault_d;
        end
    end

    assign sp_o    = sp_q;
    assign fault_o = fault_q;

endmodule

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: sequences PUSH/POP/CALL/RET/RTI/interrupt beats onto the data-memory port
module stack_op_sequencer
    import stack_seq_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int SP_RESET = sp_reset_of(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    output logic              req_ready,
    input  logic              irq,
    output logic              irq_ack,
    input  logic              ex_busy,
    input  logic [31:0]       ret_pc,
    input  logic [31:0]       call_target,
    input  logic [31:0]       int_vector,
    input  logic [15:0]       push_data,
    input  logic [2:0]        ccr_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              pc_load,
    output logic [31:0]       pc_value,
    output logic              ccr_load,
    output logic [2:0]        ccr_value,
    output logic              pop_valid,
    output logic [15:0]       pop_data,
    output logic              flush,
    output logic              freeze_fetch,
    output logic              freeze_decode,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_fault
);
    state_e            state_q, state_d;
    op_e               op_q, op_d, acc_op;
    logic [31:0]       pc_q, tgt_q;
    logic [15:0]       word_q, wdata;
    logic [2:0]        ccr_q;
    logic [1:0]        nb, beat, slot;
    logic              irq_take, req_take, in_beat, is_push, push_beat, pop_beat, done;
    logic [ADDR_W-1:0] sp_addr;

    stack_pointer #(
        .ADDR_W  (ADDR_W),
        .SP_RESET(SP_RESET)
    ) u_sp (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_beat),
        .pop_i  (pop_beat),
        .sp_o   (sp),
        .addr_o (sp_addr),
        .fault_o(stack_fault)
    );

    // Arbitration and beat decode; slot maps each beat onto hi/lo/ccr so RET and RTI share capture logic
    always_comb begin
        irq_take  = state_q == S_IDLE && irq && !ex_busy;
        req_take  = state_q == S_IDLE && !irq_take && req_valid;
        acc_op    = irq_take ? OP_INT : decode_op(req_op);
        nb        = beats_of(op_q);
        beat      = state_q == S_BEAT1 ? 2'd1 : state_q == S_BEAT2 ? 2'd2 : state_q == S_BEAT3 ? 2'd3 : 2'd0;
        in_beat   = beat != 2'd0;
        is_push   = op_q inside {OP_PUSH, OP_CALL, OP_INT};
        push_beat = in_beat && is_push;
        pop_beat  = in_beat && !is_push;
        slot      = is_push ? beat : beat + (2'd3 - nb);
        done      = state_q == S_DONE;
        wdata     = op_q == OP_PUSH ? word_q : slot == 2'd1 ? pc_q[31:16] : slot == 2'd2 ? pc_q[15:0] : {13'b0, ccr_q};
    end

    // Next state: accept in IDLE, walk the op's beats, one DONE cycle, back to IDLE
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: if (irq_take || req_take) begin
                op_d    = acc_op;
                state_d = beats_of(acc_op) == 2'd0 ? S_DONE : S_BEAT1;
            end
            S_BEAT1: state_d = nb > 2'd1 ? S_BEAT2 : S_DONE;
            S_BEAT2: state_d = nb > 2'd2 ? S_BEAT3 : S_DONE;
            S_BEAT3: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any sequence in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Operand latch on acceptance, then read-beat capture into the matching field
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            tgt_q  <= '0;
            word_q <= '0;
            ccr_q  <= '0;
        end else if (irq_take || req_take) begin
            pc_q   <= ret_pc;
            tgt_q  <= irq_take ? int_vector : call_target;
            word_q <= push_data;
            ccr_q  <= ccr_in;
        end else if (pop_beat) begin
            if (op_q == OP_POP) word_q <= mem_rdata;
            else if (slot == 2'd1) ccr_q <= mem_rdata[2:0];
            else if (slot == 2'd2) pc_q[15:0] <= mem_rdata;
            else pc_q[31:16] <= mem_rdata;
        end
    end

    // Outputs: memory beat from state, completion pulses in DONE, data buses zero when idle
    always_comb begin
        req_ready     = req_take;
        irq_ack       = irq_take;
        mem_req       = in_beat;
        mem_we        = push_beat;
        mem_addr      = in_beat ? sp_addr : '0;
        mem_wdata     = push_beat ? wdata : 16'b0;
        pc_load       = done && op_q inside {OP_CALL, OP_INT, OP_RET, OP_RTI};
        pc_value      = !pc_load ? 32'b0 : op_q inside {OP_CALL, OP_INT} ? tgt_q : pc_q;
        flush         = pc_load;
        ccr_load      = done && op_q == OP_RTI;
        ccr_value     = ccr_load ? ccr_q : 3'b0;
        pop_valid     = done && op_q == OP_POP;
        pop_data      = pop_valid ? word_q : 16'b0;
        freeze_fetch  = state_q != S_IDLE;
        freeze_decode = state_q != S_IDLE;
    end

endmodule

// File: doc/stack_op_sequencer.md
# stack_op_sequencer

Sequences every multi-beat stack transaction of the pipeline (PUSH, POP, CALL, RET, RTI, hardware interrupt) onto the single data-memory port, one beat per cycle. It owns the stack pointer and arbitrates between decode-stage requests and the external interrupt. While a sequence runs it freezes fetch/decode. On completion it drives PC/CCR reloads and the pipeline flush.

## Interface
- ADDR_W, 12: data-memory word-address width; SP width.
- SP_RESET, 2**ADDR_W-1: stack pointer value after reset (empty stack).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  decode requests a stack op; held until accepted.
- req_op  in  3  1=PUSH 2=POP 3=CALL 4=RET 5=RTI; other codes ignored (accepted as no-op).
- req_ready  out  1  request accepted this cycle.
- irq  in  1  interrupt request, level.
- irq_ack  out  1  one-cycle pulse when interrupt accepted.
- ex_busy  in  1  LDM/load-use in flight; blocks interrupt acceptance only.
- ret_pc  in  32  PC to save (CALL/interrupt).
- call_target  in  32  CALL destination.
- int_vector  in  32  interrupt handler address.
- push_data  in  16  PUSH operand.
- ccr_in  in  3  flags to save on interrupt.
- mem_req, mem_we  out  1 each  memory beat / write strobe.
- mem_addr  out  ADDR_W  beat address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid same cycle as mem_req & !mem_we.
- pc_load  out  1  pulse; load pc_value into PC.
- pc_value  out  32  new PC.
- ccr_load  out  1  pulse; load ccr_value.
- ccr_value  out  3  restored flags.
- pop_valid  out  1  pulse; pop_data valid.
- pop_data  out  16  popped word.
- flush  out  1  pulse with every pc_load.
- freeze_fetch, freeze_decode  out  1 each  high whenever state != IDLE.
- sp  out  ADDR_W  current stack pointer.
- stack_fault  out  1  sticky overflow/underflow flag.

## Operation
- Stack grows downward. Push beat: write mem[SP], SP <= SP-1. Pop beat: read mem[SP+1], SP <= SP+1. All SP arithmetic is modulo 2^ADDR_W.
- Acceptance in IDLE only. Interrupt wins when irq=1 and ex_busy=0. Otherwise a valid request is accepted (req_ready=1). A simultaneous req_valid stays pending. Operands are latched on acceptance.
- Beat sequences:
  - PUSH: W(data).
  - POP: R.
  - CALL: W(pc[31:16]), W(pc[15:0]).
  - INT: W(pc[31:16]), W(pc[15:0]), W({13'b0,ccr}).
  - RET: R(lo), R(hi).
  - RTI: R(ccr), R(lo), R(hi).
- States: IDLE, BEAT1, BEAT2, BEAT3, DONE. The op selects the beat count; BEATn proceeds to the next beat or to DONE.
- DONE outputs, one cycle, then IDLE:
  - CALL: pc_load with call_target.
  - INT: pc_load with int_vector.
  - RET/RTI: pc_load with {hi,lo}.
  - RTI additionally: ccr_load with ccr[2:0].
  - POP: pop_valid.
  - flush accompanies every pc_load.
- stack_fault sets on a push beat with SP==0, or a pop beat with SP==SP_RESET. The beat still executes (wraps). The flag clears only on rst.
- Reset values: all pulses/strobes 0, mem_addr/mem_wdata/pc_value/pop_data 0, ccr_value 0, sp=SP_RESET, stack_fault 0, state IDLE.
- rst mid-sequence aborts immediately. No partial PC/CCR load is issued; SP returns to SP_RESET.

## Timing
- Acceptance is cycle 0 (IDLE). Beats occupy cycles 1..k. DONE is cycle k+1. IDLE is cycle k+2, when the next acceptance is possible.
- Latency to pc_load: CALL and RET 3 cycles; INT and RTI 4 cycles. PUSH finishes at cycle 2 with no output pulse. POP gives pop_valid at cycle 2.
- Memory outputs are combinational from state and registers; mem_rdata is captured at the clock edge ending the beat.
- freeze_* are high in cycles 1..k+1. irq_ack and req_ready occur only in cycle 0.

## Structure
- Package stack_seq_pkg holds:
  - op codes;
  - state enum;
  - beat-count function per op;
  - default SP_RESET expression.
- Sub-module stack_pointer holds the SP register, inc/dec, next-address (SP+1) generation and fault detection.

## Test plan
- Reset, CALL with ret_pc=0x0000_0123, target=0x0000_0400 -> cycle1 write FFF=0x0000, cycle2 write FFE=0x0123, cycle3 pc_load=0x400+flush, sp=FFD.
- RET following that CALL -> reads FFE then FFF, pc_load=0x0000_0123, sp=FFF.
- irq with ccr_in=3'b101, vector 0x20 -> writes FFF/FFE/FFD (last 0x0005), pc_load=0x20 at cycle4. RTI then gives ccr_load=5 and pc_load of the saved PC.
- irq and req_valid(PUSH) same cycle, ex_busy=0 -> irq_ack first. PUSH accepted in the cycle after interrupt DONE.
- irq while ex_busy=1 for 3 cycles -> no irq_ack until ex_busy falls; a request pending in the meantime is served.
- POP at reset SP -> reads addr 000, sp wraps to 000, stack_fault=1. rst asserted mid-CALL beat2 -> no pc_load, sp=FFF, fault cleared.
